// File: rtl/run_controller.sv
// Run-control FSM in front of the 9-bit-ISA datapath: start/ack handshake, DONE/watchdog stop.
// Optional RUN_CTRL_CYCLE_STATS_EN keeps the length of the last completed run in last_cycles.
module run_controller #(
    parameter int unsigned CYC_LIMIT = 4096,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             done_dec,
    output logic             run_en,
    output logic             core_clr,
    output logic             ack,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] last_cycles
);

    typedef enum logic [1:0] {StIdle, StArmed, StRun, StFin} state_e;

    localparam logic [CNT_W-1:0] Limit = CNT_W'(CYC_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             run_en_q, core_clr_q, ack_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StArmed;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            StArmed: begin
                cnt_d     = '0;
                timeout_d = 1'b0;
                if (!start) begin
                    state_d = StRun;
                    cnt_d   = CNT_W'(1);
                end
            end
            StRun: begin
                // cnt_q counts the current RUN cycle, so the stopping cycle is included.
                if (done_dec) begin
                    state_d   = StFin;
                    timeout_d = 1'b0;
                end else if (cnt_q >= Limit) begin
                    state_d   = StFin;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StFin: begin
                if (start) begin
                    state_d   = StArmed;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they carry no input-to-output path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            run_en_q   <= 1'b0;
            core_clr_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            run_en_q   <= (state_d == StRun);
            core_clr_q <= (state_d == StArmed);
            ack_q      <= (state_d == StFin);
        end
    end

    assign run_en    = run_en_q;
    assign core_clr  = core_clr_q;
    assign ack       = ack_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cnt_q;

`ifdef RUN_CTRL_CYCLE_STATS_EN
    logic [CNT_W-1:0] last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= '0;
        end else if (state_q == StRun && state_d == StFin) begin
            last_q <= cnt_q;
        end
    end

    assign last_cycles = last_q;
`else
    assign last_cycles = '0;
`endif

endmodule
